motion_ctrl: RTL and testbench

MOTION_CTRL -- requirements
Module: motion_ctrl

---
 rtl/motion_ctrl_pkg.sv | 61 ++++++
 rtl/motion_ctrl_tick_cnt.sv | 27 ++
 rtl/motion_ctrl.sv | 151 +++++++++++++++
 tb/tb_motion_ctrl.sv | 343 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/motion_ctrl_pkg.sv
// Shared encodings for the elevator motion controller and its request stage.
package motion_ctrl_pkg;

    // Dispatch commands from the request stage; unlisted codes behave as NONE.
    typedef enum logic [2:0] {
        REQ_NONE = 3'b000,
        REQ_UP   = 3'b001,
        REQ_DOWN = 3'b010,
        REQ_OPEN = 3'b011,
        REQ_STOP = 3'b100
    } req_e;

    // One-hot motion state as seen outside the controller.
    typedef enum logic [3:0] {
        RUN_STOP = 4'b0001,
        RUN_UP   = 4'b0010,
        RUN_DOWN = 4'b0100
    } run_e;

    // One-hot door state as seen outside the controller.
    typedef enum logic [3:0] {
        DS_OPENING = 4'b0001,
        DS_OPEN    = 4'b0010,
        DS_CLOSED  = 4'b0100,
        DS_CLOSING = 4'b1000
    } door_e;

    // Controller FSM states.
    typedef enum logic [2:0] {
        ST_IDLE         = 3'd0,
        ST_MOVE_UP      = 3'd1,
        ST_MOVE_DOWN    = 3'd2,
        ST_DOOR_OPENING = 3'd3,
        ST_DOOR_OPEN    = 3'd4,
        ST_DOOR_CLOSING = 3'd5
    } state_e;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

    function automatic logic [3:0] run_code(input state_e s);
        case (s)
            ST_MOVE_UP:   return RUN_UP;
            ST_MOVE_DOWN: return RUN_DOWN;
            default:      return RUN_STOP;
        endcase
    endfunction

    function automatic logic [3:0] door_code(input state_e s);
        case (s)
            ST_DOOR_OPENING: return DS_OPENING;
            ST_DOOR_OPEN:    return DS_OPEN;
            ST_DOOR_CLOSING: return DS_CLOSING;
            default:         return DS_CLOSED;
        endcase
    endfunction

endpackage

// File: rtl/motion_ctrl_tick_cnt.sv
// Shared tick counter: clear, load, count-enable and a terminal-count flag.
module tick_cnt #(
    parameter int W = 5
) (
    input  logic         clk10hz,
    input  logic         rst,
    input  logic         clear,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         en,
    input  logic [W-1:0] limit,
    output logic         tc
);

    logic [W-1:0] count;

    // Clear beats load beats count; reset abandons any partial interval.
    always_ff @(posedge clk10hz or negedge rst) begin
        if (!rst)       count <= '0;
        else if (clear) count <= '0;
        else if (load)  count <= load_val;
        else if (en)    count <= count + W'(1);
    end

    assign tc = (count == limit);

endmodule

// File: rtl/motion_ctrl.sv
// Elevator motion/door controller: one FSM, one shared tick counter,
// registered outputs.
module motion_ctrl
    import motion_ctrl_pkg::*;
#(
    parameter int F_N          = 4,
    parameter int TRAVEL_TICKS = 20,
    parameter int DOOR_TICKS   = 10,
    parameter int HOLD_TICKS   = 30
) (
    input  logic       clk10hz,
    input  logic       rst,
    input  logic [2:0] req,
    input  logic       open_btn,
    input  logic       close_btn,
    output logic [7:0] curr_floor,
    output logic [3:0] running_state,
    output logic [3:0] door_state,
    output logic       arrive
);

    localparam int MAX_T = max3(TRAVEL_TICKS, DOOR_TICKS, HOLD_TICKS);
    localparam int CW    = (MAX_T < 2) ? 1 : $clog2(MAX_T);

    // The counter starts at 0 on state entry, so an interval of N ticks ends at N-1.
    localparam logic [CW-1:0] TRAVEL_LIM = CW'(TRAVEL_TICKS - 1);
    localparam logic [CW-1:0] DOOR_LIM   = CW'(DOOR_TICKS - 1);
    localparam logic [CW-1:0] HOLD_LIM   = CW'(HOLD_TICKS - 1);
    localparam logic [7:0]    TOP_FLOOR  = 8'(F_N - 1);

    state_e        state, state_nxt;
    logic [7:0]    floor_nxt;
    logic          arrive_nxt;
    logic          cnt_clear, cnt_load, cnt_en, cnt_tc;
    logic [CW-1:0] cnt_limit;
    logic          is_up, is_down, is_open, is_stop;

    assign is_up   = (req == REQ_UP);
    assign is_down = (req == REQ_DOWN);
    assign is_open = (req == REQ_OPEN);
    assign is_stop = (req == REQ_STOP);

    tick_cnt #(.W(CW)) u_tick_cnt (
        .clk10hz  (clk10hz),
        .rst      (rst),
        .clear    (cnt_clear),
        .load     (cnt_load),
        .load_val ('0),
        .en       (cnt_en),
        .limit    (cnt_limit),
        .tc       (cnt_tc)
    );

    // Next state, floor/arrive next values and counter control.
    always_comb begin
        state_nxt  = state;
        floor_nxt  = curr_floor;
        arrive_nxt = 1'b0;
        cnt_clear  = 1'b0;
        cnt_load   = 1'b0;
        cnt_en     = 1'b0;
        cnt_limit  = '0;
        case (state)
            ST_IDLE: begin
                cnt_clear = 1'b1;
                if (is_open || open_btn)                    state_nxt = ST_DOOR_OPENING;
                else if (is_up && curr_floor < TOP_FLOOR)   state_nxt = ST_MOVE_UP;
                else if (is_down && curr_floor != 8'd0)     state_nxt = ST_MOVE_DOWN;
            end
            ST_MOVE_UP, ST_MOVE_DOWN: begin
                cnt_limit = TRAVEL_LIM;
                if (cnt_tc) begin
                    // req is only looked at here; mid-segment changes are ignored.
                    cnt_clear  = 1'b1;
                    arrive_nxt = 1'b1;
                    floor_nxt  = (state == ST_MOVE_UP) ? curr_floor + 8'd1 : curr_floor - 8'd1;
                    if (is_open)
                        state_nxt = ST_DOOR_OPENING;
                    else if (is_stop ||
                             (state == ST_MOVE_UP   && floor_nxt == TOP_FLOOR) ||
                             (state == ST_MOVE_DOWN && floor_nxt == 8'd0))
                        state_nxt = ST_IDLE;
                end else begin
                    cnt_en = 1'b1;
                end
            end
            ST_DOOR_OPENING: begin
                cnt_limit = DOOR_LIM;
                if (cnt_tc) begin
                    cnt_clear = 1'b1;
                    state_nxt = ST_DOOR_OPEN;
                end else begin
                    cnt_en = 1'b1;
                end
            end
            ST_DOOR_OPEN: begin
                cnt_limit = HOLD_LIM;
                // Holding open restarts the hold interval from zero.
                if (open_btn) begin
                    cnt_load = 1'b1;
                end else if (close_btn || cnt_tc) begin
                    cnt_clear = 1'b1;
                    state_nxt = ST_DOOR_CLOSING;
                end else begin
                    cnt_en = 1'b1;
                end
            end
            ST_DOOR_CLOSING: begin
                cnt_limit = DOOR_LIM;
                if (open_btn || is_open) begin
                    cnt_clear = 1'b1;
                    state_nxt = ST_DOOR_OPENING;
                end else if (cnt_tc) begin
                    cnt_clear = 1'b1;
                    state_nxt = ST_IDLE;
                end else begin
                    cnt_en = 1'b1;
                end
            end
            default: begin
                cnt_clear = 1'b1;
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // State, floor and arrive registers.
    always_ff @(posedge clk10hz or negedge rst) begin
        if (!rst) begin
            state      <= ST_IDLE;
            curr_floor <= 8'd0;
            arrive     <= 1'b0;
        end else begin
            state      <= state_nxt;
            curr_floor <= floor_nxt;
            arrive     <= arrive_nxt;
        end
    end

    // Motion/door outputs follow the state register one cycle later.
    always_ff @(posedge clk10hz or negedge rst) begin
        if (!rst) begin
            running_state <= RUN_STOP;
            door_state    <= DS_CLOSED;
        end else begin
            running_state <= run_code(state);
            door_state    <= door_code(state);
        end
    end

endmodule

// File: tb/tb_motion_ctrl.sv
// Bench for motion_ctrl: directed scenarios plus randomized traffic, all
// compared against a behavioural elevator model.
module tb_motion_ctrl;

    localparam int F_N = 4;
    localparam int TT  = 20;
    localparam int DT  = 10;
    localparam int HT  = 30;

    localparam logic [2:0] R_NONE = 3'b000;
    localparam logic [2:0] R_UP   = 3'b001;
    localparam logic [2:0] R_DOWN = 3'b010;
    localparam logic [2:0] R_OPEN = 3'b011;
    localparam logic [2:0] R_STOP = 3'b100;

    localparam int M_IDLE = 0, M_UP = 1, M_DN = 2, M_OPENING = 3, M_OPEN = 4, M_CLOSING = 5;

    logic       clk10hz = 1'b0;
    logic       rst = 1'b0;
    logic [2:0] req = 3'b000;
    logic       open_btn = 1'b0;
    logic       close_btn = 1'b0;
    logic [7:0] curr_floor;
    logic [3:0] running_state, door_state;
    logic       arrive;

    int vectors = 0;
    int miscompares = 0;

    // Behavioural model: where the car is and how long it has been doing it.
    int         m_mode;
    int         m_el;
    logic [7:0] m_floor;
    logic       m_arr;
    logic [3:0] m_run, m_door;

    motion_ctrl #(.F_N(F_N), .TRAVEL_TICKS(TT), .DOOR_TICKS(DT), .HOLD_TICKS(HT)) dut (
        .clk10hz       (clk10hz),
        .rst           (rst),
        .req           (req),
        .open_btn      (open_btn),
        .close_btn     (close_btn),
        .curr_floor    (curr_floor),
        .running_state (running_state),
        .door_state    (door_state),
        .arrive        (arrive)
    );

    always #5 clk10hz = ~clk10hz;

    task automatic model_reset();
        m_mode = M_IDLE; m_el = 0; m_floor = 8'd0; m_arr = 1'b0;
        m_run = 4'b0001; m_door = 4'b0100;
    endtask

    // Advance the model by one clock with the given inputs.
    task automatic model_step(input logic [2:0] r, input logic ob, input logic cb);
        bit op, up, dn, st;
        op = (r == R_OPEN); up = (r == R_UP); dn = (r == R_DOWN); st = (r == R_STOP);
        // outputs show what the car was doing before this edge
        m_run  = (m_mode == M_UP) ? 4'b0010 : (m_mode == M_DN) ? 4'b0100 : 4'b0001;
        m_door = (m_mode == M_OPENING) ? 4'b0001 : (m_mode == M_OPEN) ? 4'b0010 :
                 (m_mode == M_CLOSING) ? 4'b1000 : 4'b0100;
        m_arr  = 1'b0;
        case (m_mode)
            M_IDLE: begin
                m_el = 0;
                if (op || ob) m_mode = M_OPENING;
                else if (up && m_floor < F_N - 1) m_mode = M_UP;
                else if (dn && m_floor > 0) m_mode = M_DN;
            end
            M_UP, M_DN: begin
                m_el++;
                if (m_el == TT) begin
                    m_el = 0;
                    m_arr = 1'b1;
                    if (m_mode == M_UP) m_floor = m_floor + 8'd1;
                    else m_floor = m_floor - 8'd1;
                    if (op) m_mode = M_OPENING;
                    else if (st || (m_mode == M_UP && m_floor == F_N - 1) ||
                             (m_mode == M_DN && m_floor == 0)) m_mode = M_IDLE;
                end
            end
            M_OPENING: begin
                m_el++;
                if (m_el == DT) begin m_el = 0; m_mode = M_OPEN; end
            end
            M_OPEN: begin
                if (ob) m_el = 0;
                else begin
                    m_el++;
                    if (cb || m_el == HT) begin m_el = 0; m_mode = M_CLOSING; end
                end
            end
            default: begin
                if (ob || op) begin m_el = 0; m_mode = M_OPENING; end
                else begin
                    m_el++;
                    if (m_el == DT) begin m_el = 0; m_mode = M_IDLE; end
                end
            end
        endcase
    endtask

    // One clock: drive on the falling edge, sample 1 time unit after the rising edge.
    task automatic apply(input logic [2:0] r, input logic ob, input logic cb);
        @(negedge clk10hz);
        req = r; open_btn = ob; close_btn = cb;
        model_step(r, ob, cb);
        @(posedge clk10hz);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        model_reset();
        for (int i = 0; i < 3; i++) begin
            @(posedge clk10hz); #1;
            vectors++;
            if ({curr_floor, running_state, door_state, arrive} !== {8'd0, 4'b0001, 4'b0100, 1'b0}) begin
                miscompares++;
                $display("FAIL reset: got floor=%0d run=%b door=%b arrive=%b, want 0/0001/0100/0",
                         curr_floor, running_state, door_state, arrive);
            end
        end
        rst = 1'b1;
    endtask

    task automatic test_up_run();
        logic [7:0] ef;
        logic [3:0] er;
        logic       ea;
        for (int n = 1; n <= 64; n++) begin
            apply(R_UP, 1'b0, 1'b0);
            ea = (n == 21 || n == 41 || n == 61);
            ef = (n < 21) ? 8'd0 : (n < 41) ? 8'd1 : (n < 61) ? 8'd2 : 8'd3;
            er = (n == 1 || n >= 62) ? 4'b0001 : 4'b0010;
            vectors++;
            if ({curr_floor, running_state, door_state, arrive} !== {ef, er, 4'b0100, ea}) begin
                miscompares++;
                $display("FAIL up_run cyc %0d: got floor=%0d run=%b door=%b arrive=%b, want %0d/%b/0100/%b",
                         n, curr_floor, running_state, door_state, arrive, ef, er, ea);
            end
            vectors++;
            if ({curr_floor, running_state, door_state, arrive} !== {m_floor, m_run, m_door, m_arr}) begin
                miscompares++;
                $display("FAIL up_run_model cyc %0d: got %0d/%b/%b/%b, want %0d/%b/%b/%b", n,
                         curr_floor, running_state, door_state, arrive, m_floor, m_run, m_door, m_arr);
            end
        end
    endtask

    task automatic test_down_stop();
        logic [2:0] r;
        // from floor 3 down to floor 1, stopping at the arrival
        for (int n = 1; n <= 43; n++) begin
            r = (n == 1) ? R_DOWN : (n == 41) ? R_STOP : R_NONE;
            apply(r, 1'b0, 1'b0);
            vectors++;
            if ({curr_floor, running_state, door_state, arrive} !== {m_floor, m_run, m_door, m_arr}) begin
                miscompares++;
                $display("FAIL down_to_1 cyc %0d: got %0d/%b/%b/%b, want %0d/%b/%b/%b", n,
                         curr_floor, running_state, door_state, arrive, m_floor, m_run, m_door, m_arr);
            end
        end
        // one cycle of DOWN at floor 1, then STOP; later DOWN at floor 0 is ignored
        for (int n = 1; n <= 28; n++) begin
            r = (n == 1 || n > 24) ? R_DOWN : R_STOP;
            apply(r, 1'b0, 1'b0);
            vectors++;
            if ({curr_floor, running_state, door_state, arrive} !== {m_floor, m_run, m_door, m_arr}) begin
                miscompares++;
                $display("FAIL down_stop cyc %0d: got %0d/%b/%b/%b, want %0d/%b/%b/%b", n,
                         curr_floor, running_state, door_state, arrive, m_floor, m_run, m_door, m_arr);
            end
            if (n == 21) begin
                vectors++;
                if (curr_floor !== 8'd0 || arrive !== 1'b1) begin
                    miscompares++;
                    $display("FAIL down_arrive: got floor=%0d arrive=%b, want 0/1", curr_floor, arrive);
                end
            end
            if (n >= 22) begin
                vectors++;
                if (running_state !== 4'b0001 || curr_floor !== 8'd0) begin
                    miscompares++;
                    $display("FAIL down_ignored cyc %0d: got run=%b floor=%0d, want 0001/0",
                             n, running_state, curr_floor);
                end
            end
        end
    endtask

    task automatic test_door_cycle();
        logic [2:0] r;
        logic [3:0] ed;
        // ride up to floor 2
        for (int n = 1; n <= 42; n++) begin
            r = (n == 1) ? R_UP : (n == 41) ? R_STOP : R_NONE;
            apply(r, 1'b0, 1'b0);
        end
        vectors++;
        if (curr_floor !== 8'd2 || running_state !== 4'b0001) begin
            miscompares++;
            $display("FAIL reach_floor2: got floor=%0d run=%b, want 2/0001", curr_floor, running_state);
        end
        for (int n = 1; n <= 56; n++) begin
            apply((n == 1) ? R_OPEN : R_NONE, 1'b0, 1'b0);
            ed = (n == 1) ? 4'b0100 : (n <= 11) ? 4'b0001 : (n <= 41) ? 4'b0010 :
                 (n <= 51) ? 4'b1000 : 4'b0100;
            vectors++;
            if (door_state !== ed || running_state !== 4'b0001) begin
                miscompares++;
                $display("FAIL door_cycle cyc %0d: got door=%b run=%b, want %b/0001",
                         n, door_state, running_state, ed);
            end
            vectors++;
            if ({curr_floor, running_state, door_state, arrive} !== {m_floor, m_run, m_door, m_arr}) begin
                miscompares++;
                $display("FAIL door_model cyc %0d: got %0d/%b/%b/%b, want %0d/%b/%b/%b", n,
                         curr_floor, running_state, door_state, arrive, m_floor, m_run, m_door, m_arr);
            end
        end
    endtask

    task automatic test_hold_extend();
        logic ob, cb;
        for (int n = 1; n <= 63; n++) begin
            ob = (n >= 37 && n <= 41);
            cb = (n == 62);
            apply((n == 1) ? R_OPEN : R_NONE, ob, cb);
            vectors++;
            if ({curr_floor, running_state, door_state, arrive} !== {m_floor, m_run, m_door, m_arr}) begin
                miscompares++;
                $display("FAIL hold_model cyc %0d: got %0d/%b/%b/%b, want %0d/%b/%b/%b", n,
                         curr_floor, running_state, door_state, arrive, m_floor, m_run, m_door, m_arr);
            end
            if (n >= 12 && n <= 62) begin
                vectors++;
                if (door_state !== 4'b0010) begin
                    miscompares++;
                    $display("FAIL hold_extend cyc %0d: got door=%b, want 0010", n, door_state);
                end
            end
        end
        vectors++;
        if (door_state !== 4'b1000) begin
            miscompares++;
            $display("FAIL close_btn: got door=%b, want 1000", door_state);
        end
    endtask

    task automatic test_reopen();
        logic [3:0] ed;
        for (int n = 1; n <= 60; n++) begin
            apply(R_NONE, (n == 5), 1'b0);
            ed = (n <= 5) ? 4'b1000 : (n <= 15) ? 4'b0001 : (n <= 45) ? 4'b0010 :
                 (n <= 55) ? 4'b1000 : 4'b0100;
            vectors++;
            if (door_state !== ed) begin
                miscompares++;
                $display("FAIL reopen cyc %0d: got door=%b, want %b", n, door_state, ed);
            end
            vectors++;
            if ({curr_floor, running_state, door_state, arrive} !== {m_floor, m_run, m_door, m_arr}) begin
                miscompares++;
                $display("FAIL reopen_model cyc %0d: got %0d/%b/%b/%b, want %0d/%b/%b/%b", n,
                         curr_floor, running_state, door_state, arrive, m_floor, m_run, m_door, m_arr);
            end
        end
    endtask

    task automatic test_reset_mid_move();
        for (int n = 1; n <= 11; n++) apply((n == 1) ? R_UP : R_NONE, 1'b0, 1'b0);
        vectors++;
        if (running_state !== 4'b0010) begin
            miscompares++;
            $display("FAIL pre_reset_move: got run=%b, want 0010", running_state);
        end
        #2 rst = 1'b0;
        #1;
        vectors++;
        if ({curr_floor, running_state, door_state, arrive} !== {8'd0, 4'b0001, 4'b0100, 1'b0}) begin
            miscompares++;
            $display("FAIL async_reset: got %0d/%b/%b/%b, want 0/0001/0100/0",
                     curr_floor, running_state, door_state, arrive);
        end
        for (int n = 0; n < 12; n++) begin
            @(posedge clk10hz); #1;
            vectors++;
            if (arrive !== 1'b0 || curr_floor !== 8'd0) begin
                miscompares++;
                $display("FAIL reset_hold: got arrive=%b floor=%0d, want 0/0", arrive, curr_floor);
            end
        end
        rst = 1'b1;
        model_reset();
    endtask

    task automatic test_random();
        logic [2:0] r;
        int         p;
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 499) == 0) begin
                #2 rst = 1'b0;
                #1;
                vectors++;
                if ({curr_floor, running_state, door_state, arrive} !== {8'd0, 4'b0001, 4'b0100, 1'b0}) begin
                    miscompares++;
                    $display("FAIL rand_reset: got %0d/%b/%b/%b, want 0/0001/0100/0",
                             curr_floor, running_state, door_state, arrive);
                end
                @(posedge clk10hz); #1;
                rst = 1'b1;
                model_reset();
            end
            p = $urandom_range(0, 99);
            r = (p < 60) ? R_NONE : (p < 70) ? R_UP : (p < 80) ? R_DOWN :
                (p < 85) ? R_OPEN : (p < 93) ? R_STOP : 3'($urandom_range(5, 7));
            apply(r, ($urandom_range(0, 99) < 4), ($urandom_range(0, 99) < 6));
            vectors++;
            if ({curr_floor, running_state, door_state, arrive} !== {m_floor, m_run, m_door, m_arr}) begin
                miscompares++;
                $display("FAIL random cyc %0d: got %0d/%b/%b/%b, want %0d/%b/%b/%b", n,
                         curr_floor, running_state, door_state, arrive, m_floor, m_run, m_door, m_arr);
            end
        end
    endtask

    initial begin
        test_reset();
        test_up_run();
        test_down_stop();
        test_door_cycle();
        test_hold_extend();
        test_reopen();
        test_reset_mid_move();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
